// File: rtl/bf_control_unit_if.sv
// Bus between the Brainfuck sequencer and its external PC/datapath/program memory.
// master = sequencer side, slave = datapath side.
interface bf_control_unit_if #(
  parameter int CMD_W = 6
);
  logic             iowait;
  logic             zeroflag;
  logic [3:0]       instruction;
  logic             pc_inc;
  logic             pc_dec;
  logic [CMD_W-1:0] command;
  logic             halted;
  logic             nest_err;

  modport master (
    input  iowait, zeroflag, instruction,
    output pc_inc, pc_dec, command, halted, nest_err
  );

  modport slave (
    output iowait, zeroflag, instruction,
    input  pc_inc, pc_dec, command, halted, nest_err
  );
endinterface

// File: rtl/bf_control_unit.sv
// Brainfuck-style control sequencer: 2-cycle fetch/execute, bracket skipping, I/O wait, HALT.
// Define BF_DEBUG_STEP_EN to add single-step gating (step input, at_fetch output).
module bf_control_unit #(
  parameter int DEPTH_W = 4,
  parameter int CMD_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BF_DEBUG_STEP_EN
  input  logic step,
  output logic at_fetch,
`endif
  bf_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_IOWAIT,
    S_SKIP_F,
    S_SKIP_B,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_OUT   = 4'd5;
  localparam logic [3:0] OP_IN    = 4'd6;
  localparam logic [3:0] OP_OPEN  = 4'd7;
  localparam logic [3:0] OP_CLOSE = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state_reg;
  logic [DEPTH_W-1:0] depth_reg;
  logic               pc_inc_reg;
  logic               pc_dec_reg;
  logic [5:0]         cmd_reg;
  logic               halted_reg;
  logic               nest_err_reg;
  // High during the pulse half of a 2-cycle skip step; the other half samples.
  logic               skip_pulse_reg;

  logic       go;
  logic       is_open;
  logic       is_close;
  logic       is_io;
  logic [5:0] op_cmd;

`ifdef BF_DEBUG_STEP_EN
  assign go       = step;
  assign at_fetch = (state_reg == S_FETCH);
`else
  assign go = 1'b1;
`endif

  assign is_open  = (bus.instruction == OP_OPEN);
  assign is_close = (bus.instruction == OP_CLOSE);
  assign is_io    = (bus.instruction == OP_OUT) || (bus.instruction == OP_IN);

  always_comb begin
    op_cmd = 6'b000000;
    case (bus.instruction)
      OP_INC:   op_cmd = 6'b000001;
      OP_DEC:   op_cmd = 6'b000010;
      OP_RIGHT: op_cmd = 6'b000100;
      OP_LEFT:  op_cmd = 6'b001000;
      OP_OUT:   op_cmd = 6'b010000;
      OP_IN:    op_cmd = 6'b100000;
      default:  op_cmd = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_FETCH;
      depth_reg      <= '0;
      pc_inc_reg     <= 1'b0;
      pc_dec_reg     <= 1'b0;
      cmd_reg        <= 6'b000000;
      halted_reg     <= 1'b0;
      nest_err_reg   <= 1'b0;
      skip_pulse_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (go) begin
            if (bus.instruction == OP_HALT) begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end else if (is_io) begin
              // The io strobe is raised now and held through any wait.
              cmd_reg    <= op_cmd;
              pc_inc_reg <= !bus.iowait;
              state_reg  <= bus.iowait ? S_IOWAIT : S_EXEC;
            end else if (is_open && bus.zeroflag) begin
              depth_reg      <= DEPTH_ONE;
              pc_inc_reg     <= 1'b1;
              skip_pulse_reg <= 1'b1;
              state_reg      <= S_SKIP_F;
            end else if (is_close && !bus.zeroflag) begin
              depth_reg      <= DEPTH_ONE;
              pc_dec_reg     <= 1'b1;
              skip_pulse_reg <= 1'b1;
              state_reg      <= S_SKIP_B;
            end else begin
              pc_inc_reg <= 1'b1;
              cmd_reg    <= op_cmd;
              state_reg  <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          pc_inc_reg <= 1'b0;
          pc_dec_reg <= 1'b0;
          cmd_reg    <= 6'b000000;
          state_reg  <= S_FETCH;
        end

        S_IOWAIT: begin
          if (go && !bus.iowait) begin
            pc_inc_reg <= 1'b1;
            state_reg  <= S_EXEC;
          end
        end

        S_SKIP_F: begin
          if (skip_pulse_reg) begin
            pc_inc_reg     <= 1'b0;
            skip_pulse_reg <= 1'b0;
          end else if (go) begin
            if (is_open && depth_reg == DEPTH_MAX) begin
              nest_err_reg <= 1'b1;
              halted_reg   <= 1'b1;
              state_reg    <= S_HALT;
            end else begin
              pc_inc_reg <= 1'b1;
              if (is_open) begin
                depth_reg <= depth_reg + DEPTH_ONE;
              end else if (is_close) begin
                depth_reg <= depth_reg - DEPTH_ONE;
              end
              // Matching ']' found: its pc_inc pulse is the final one.
              if (is_close && depth_reg == DEPTH_ONE) begin
                state_reg <= S_EXEC;
              end else begin
                skip_pulse_reg <= 1'b1;
              end
            end
          end
        end

        S_SKIP_B: begin
          if (skip_pulse_reg) begin
            pc_dec_reg     <= 1'b0;
            skip_pulse_reg <= 1'b0;
          end else if (go) begin
            if (is_close && depth_reg == DEPTH_MAX) begin
              nest_err_reg <= 1'b1;
              halted_reg   <= 1'b1;
              state_reg    <= S_HALT;
            end else if (is_open && depth_reg == DEPTH_ONE) begin
              // Step forward past the matching '[' so its body runs next.
              depth_reg  <= '0;
              pc_inc_reg <= 1'b1;
              state_reg  <= S_EXEC;
            end else begin
              pc_dec_reg     <= 1'b1;
              skip_pulse_reg <= 1'b1;
              if (is_close) begin
                depth_reg <= depth_reg + DEPTH_ONE;
              end else if (is_open) begin
                depth_reg <= depth_reg - DEPTH_ONE;
              end
            end
          end
        end

        S_HALT: begin
          pc_inc_reg <= 1'b0;
          pc_dec_reg <= 1'b0;
          cmd_reg    <= 6'b000000;
        end

        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.pc_inc   = pc_inc_reg;
  assign bus.pc_dec   = pc_dec_reg;
  assign bus.halted   = halted_reg;
  assign bus.nest_err = nest_err_reg;

  generate
    for (genvar gi = 0; gi < CMD_W; gi++) begin : g_cmd
      if (gi < 6) begin : g_used
        assign bus.command[gi] = cmd_reg[gi];
      end else begin : g_zero
        assign bus.command[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_bf_control_unit.sv
// Directed bench for bf_control_unit: an instruction-level interpreter predicts the per-cycle
// output trace, a compare process checks it every cycle, and literal checks pin key results.
module tb_bf_control_unit;

  localparam int DEPTH_W = 2;
  localparam int CMD_W   = 6;
  localparam int MAXN    = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bf_control_unit_if #(.CMD_W(CMD_W)) bus ();

`ifdef BF_DEBUG_STEP_EN
  logic at_fetch_w;
`endif

  bf_control_unit #(.DEPTH_W(DEPTH_W), .CMD_W(CMD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef BF_DEBUG_STEP_EN
    .step     (1'b1),
    .at_fetch (at_fetch_w),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Program, environment and expected trace
  logic [3:0] mem [16];
  bit         iow [MAXN];
  bit         zf;
  bit         e_inc  [MAXN];
  bit         e_dec  [MAXN];
  logic [5:0] e_cmd  [MAXN];
  bit         e_halt [MAXN];
  bit         e_nest [MAXN];

  int cyc = 0;
  bit checking = 1'b0;
  int pc = 0;
  int n_inc, n_dec, n_out, n_in, n_ptr, n_cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic halt_from(input int t, input bit ov);
    for (int i = t; i < MAXN; i++) begin
      e_halt[i] = 1'b1;
      e_nest[i] = ov;
    end
  endtask

  // Interpreter: walks the program one instruction at a time, counting cycles.
  task automatic build_model(input int n, input int start);
    int t, p, depth, op, maxd;
    logic [5:0] bitv;
    bit stop;
    for (int i = 0; i < MAXN; i++) begin
      e_inc[i] = 0; e_dec[i] = 0; e_cmd[i] = '0; e_halt[i] = 0; e_nest[i] = 0;
    end
    maxd = (1 << DEPTH_W) - 1;
    p = start; t = 0; stop = 0;
    while (t < n && !stop) begin
      op = int'(mem[p & 15]);
      t++;
      if (op == 9) begin
        halt_from(t, 1'b0);
        stop = 1;
      end else if (op == 5 || op == 6) begin
        bitv = (op == 5) ? 6'b010000 : 6'b100000;
        if (iow[t-1]) begin
          while (t < n && iow[t]) begin e_cmd[t] = bitv; t++; end
          e_cmd[t] = bitv; t++;
        end
        e_inc[t] = 1; e_cmd[t] = bitv; p++; t++;
      end else if (op == 7 && zf) begin
        depth = 1; e_inc[t] = 1; p++; t++;
        while (depth > 0 && t < n) begin
          op = int'(mem[p & 15]); t++;
          if (op == 7) begin
            if (depth == maxd) begin halt_from(t, 1'b1); stop = 1; break; end
            depth++;
          end else if (op == 8) depth--;
          e_inc[t] = 1; p++; t++;
        end
      end else if (op == 8 && !zf) begin
        depth = 1; e_dec[t] = 1; p--; t++;
        while (t < n) begin
          op = int'(mem[p & 15]); t++;
          if (op == 8) begin
            if (depth == maxd) begin halt_from(t, 1'b1); stop = 1; break; end
            depth++;
          end else if (op == 7) depth--;
          if (depth == 0) begin e_inc[t] = 1; p++; t++; break; end
          e_dec[t] = 1; p--; t++;
        end
      end else begin
        e_inc[t] = 1;
        if (op >= 1 && op <= 4) e_cmd[t] = 6'(1 << (op - 1));
        p++; t++;
      end
    end
  endtask

  // Per-cycle comparison against the interpreter's trace
  always @(negedge clk) begin
    #1;
    if (checking) begin
      chk($sformatf("c%0d pc_inc", cyc), 32'(bus.pc_inc), 32'(e_inc[cyc]));
      chk($sformatf("c%0d pc_dec", cyc), 32'(bus.pc_dec), 32'(e_dec[cyc]));
      chk($sformatf("c%0d command", cyc), 32'(bus.command), 32'(e_cmd[cyc]));
      chk($sformatf("c%0d halted", cyc), 32'(bus.halted), 32'(e_halt[cyc]));
      chk($sformatf("c%0d nest_err", cyc), 32'(bus.nest_err), 32'(e_nest[cyc]));
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    for (int i = 0; i < MAXN; i++) iow[i] = 1'b0;
  endtask

  task automatic run_test(input string name, input int n, input int start);
    build_model(n, start);
    n_inc = 0; n_dec = 0; n_out = 0; n_in = 0; n_ptr = 0; n_cmd = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({name, " reset pulses"}, 32'({bus.pc_inc, bus.pc_dec}), 32'd0);
    chk({name, " reset command"}, 32'(bus.command), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pc = start;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      cyc = c;
      checking = 1'b1;
      bus.instruction = mem[pc & 15];
      bus.iowait = iow[c];
      bus.zeroflag = zf;
      if (bus.pc_inc) n_inc++;
      if (bus.pc_dec) n_dec++;
      if (bus.command == 6'b010000) n_out++;
      if (bus.command == 6'b100000) n_in++;
      if (bus.command == 6'b000100) n_ptr++;
      if (bus.command != '0) n_cmd++;
      pc = pc + int'(bus.pc_inc) - int'(bus.pc_dec);
    end
    #2;
    checking = 1'b0;
    $display("[TB] %s: %0d cycles, pc=%0d inc=%0d dec=%0d", name, n, pc, n_inc, n_dec);
  endtask

  initial begin
    bus.iowait = 1'b0;
    bus.zeroflag = 1'b0;
    bus.instruction = 4'd0;

    // '+' held: a pulse every other cycle
    clear_prog();
    for (int i = 0; i < 16; i++) mem[i] = 4'd1;
    zf = 1'b0;
    run_test("plus", 9, 0);
    chk("plus pc", 32'(pc), 32'd4);
    chk("plus inc count", 32'(n_inc), 32'd4);

    // OUT stalled 5 cycles, then IN without wait
    clear_prog();
    mem[0] = 4'd5; mem[1] = 4'd6;
    for (int i = 0; i < 5; i++) iow[i] = 1'b1;
    zf = 1'b0;
    run_test("io", 9, 0);
    chk("io pc", 32'(pc), 32'd2);
    chk("io out cycles", 32'(n_out), 32'd6);
    chk("io in cycles", 32'(n_in), 32'd1);
    chk("io inc count", 32'(n_inc), 32'd2);

    // Forward skip over "[ + [ - ] ]", then '>' at PC 6
    clear_prog();
    mem[0] = 4'd7; mem[1] = 4'd1; mem[2] = 4'd7; mem[3] = 4'd2;
    mem[4] = 4'd8; mem[5] = 4'd8; mem[6] = 4'd3;
    zf = 1'b1;
    run_test("skip_fwd", 12, 0);
    chk("skip_fwd pc", 32'(pc), 32'd6);
    chk("skip_fwd no cmd", 32'(n_cmd), 32'd0);
    run_test("skip_fwd_resume", 14, 0);
    chk("skip_fwd_resume pc", 32'(pc), 32'd7);
    chk("skip_fwd_resume ptr", 32'(n_ptr), 32'd1);

    // Backward skip "[ > ]" from PC 2
    clear_prog();
    mem[0] = 4'd7; mem[1] = 4'd3; mem[2] = 4'd8;
    zf = 1'b0;
    run_test("skip_back", 8, 2);
    chk("skip_back pc", 32'(pc), 32'd2);
    chk("skip_back dec count", 32'(n_dec), 32'd2);
    chk("skip_back ptr", 32'(n_ptr), 32'd1);

    // Nesting overflow with max depth 3
    clear_prog();
    for (int i = 0; i < 4; i++) mem[i] = 4'd7;
    zf = 1'b1;
    run_test("overflow", 20, 0);
    chk("overflow pc", 32'(pc), 32'd3);
    chk("overflow nest_err", 32'(bus.nest_err), 32'd1);
    chk("overflow halted", 32'(bus.halted), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("overflow rst nest_err", 32'(bus.nest_err), 32'd0);
    chk("overflow rst halted", 32'(bus.halted), 32'd0);

    // HALT opcode
    clear_prog();
    mem[0] = 4'd9; mem[1] = 4'd1;
    zf = 1'b0;
    run_test("halt", 22, 0);
    chk("halt halted", 32'(bus.halted), 32'd1);
    chk("halt no pulses", 32'(n_inc + n_dec), 32'd0);
    chk("halt no cmd", 32'(n_cmd), 32'd0);

    // Asynchronous reset while stalled in IN
    clear_prog();
    mem[0] = 4'd6;
    for (int i = 0; i < MAXN; i++) iow[i] = 1'b1;
    zf = 1'b0;
    run_test("io_reset", 5, 0);
    chk("io_reset cmd before", 32'(bus.command), 32'h20);
    rst_n = 1'b0;
    #1;
    chk("io_reset cmd after", 32'(bus.command), 32'd0);
    chk("io_reset pc_inc after", 32'(bus.pc_inc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
